mod_exp_engine: RTL
===================

// Module: mod_exp_engine
// PURPOSE
//  Datapath for the RSA encrypt/decrypt step: result = base^exponent mod modulus.
//  Consumes load/running from the RSA control FSM and returns the over pulse that ends its run state.
//  Fixed-schedule square-and-multiply: every exponent bit costs the same cycles, so latency is data-independent.
//  Each modular multiply is bit-serial interleaved (shift/add/subtract): one multiplier bit per cycle.
// PARAMETERS
//  WIDTH  16  operand width in bits for base, exponent, modulus and result (>=2)
// PORTS
//  clk       in   1      rising-edge clock; only clock in the block
//  reset     in   1      synchronous, active-low reset (sampled on clk rising edge when 0)
//  load      in   1      latch operands and restart computation (priority over running)
//  running   in   1      advance enable; 0 = hold all state (stall)
//  base      in   WIDTH  message/ciphertext; sampled only on load
//  exponent  in   WIDTH  e or d; sampled only on load
//  modulus   in   WIDTH  n; sampled only on load
//  result    out  WIDTH  base^exponent mod modulus; valid from over, held until next load/reset
//  over      out  1      one-cycle completion pulse (registered)
//  err       out  1      operand error flag, valid with over, held until next load/reset
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE; result=0, over=0, err=0; internal B,R,E,M,P,counters=0.
//  Reset wins over load/running in the same cycle; reset mid-operation aborts, no over is produced.
//  Load (load==1 at edge, any state): M<=modulus, E<=exponent, B<=base, R<=(modulus==1)?0:1,
//   bit_cnt<=WIDTH-1, step_cnt<=WIDTH-1, over<=0, err<=0, result<=0, state<=MUL. Load mid-run restarts.
//  States: IDLE -> MUL -> SQR -> (MUL | FIN) -> IDLE. All non-IDLE states advance only when running==1.
//  MUL (WIDTH cycles): P = modmul(R, B); at step_cnt==0, if E[0]==1 then R<=P else R unchanged; -> SQR.
//  SQR (WIDTH cycles): P = modmul(B, B); at step_cnt==0 B<=P, E<=E>>1; bit_cnt==0 ? FIN : MUL (bit_cnt--).
//  modmul(X,Y): P starts 0 at first step; per cycle i=WIDTH-1..0:
//   P=2P; if P>=M then P-=M; if Y[i] then P+=X; if P>=M then P-=M.  P and sums are WIDTH+1 bits.
//   Requires X,Y<M; the P+X intermediate fits in WIDTH+1 bits and is never truncated.
//  FIN (1 cycle, independent of running): result<=R, over<=1 for exactly one cycle, state<=IDLE.
//  Latency: over is high in the cycle following edge 2*WIDTH*WIDTH+1 counted from the load edge,
//   plus one cycle per stalled (running==0) cycle. WIDTH=16: 513 edges.
//  IDLE: holds result/err; over=0; running ignored.
//  err: set at load when modulus==0 or base>=modulus; schedule still runs (constant latency),
//   but FIN forces result<=0; err stays 1 until next load/reset.
//  exponent==0: no commits in MUL; result=1 (0 if modulus==1).
//  Back-to-back: load may be asserted in the FIN cycle's following cycle; load in FIN cycle restarts and suppresses over.
// TESTING
//  WIDTH=16 for all; running held 1 unless stated; over counted in cycles after load edge.
//  T1: base=4, exp=13, mod=497 -> result=445, err=0, over 1-cycle pulse at edge 513.
//  T2: base=7, exp=560, mod=561 -> result=1; base=65534, exp=65535, mod=65535 -> result=65534 (carry path).
//  T3: exp=0, base=3, mod=7 -> result=1; base=5, exp=9, mod=1 -> result=0; mod=0 -> err=1, result=0, over at 513.
//  T4: T1 operands, running=0 for 37 cycles mid-run -> over at edge 550, result=445; outputs frozen while stalled.
//  T5: load T1 then at edge 200 load base=2,exp=10,mod=1000 -> single over at edge 713, result=24.
//  T6: reset=0 at edge 300 of T1 run -> result=0, over never asserts; state IDLE; fresh load then runs normally.

Source files
------------

// File: rtl/mod_exp_engine_if.sv
// Operand/result bundle between the RSA control FSM and the modular exponentiation datapath.
interface mod_exp_if #(
  parameter int WIDTH = 16
);
  logic             load;
  logic             running;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] exponent;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] result;
  logic             over;
  logic             err;

  modport master (
    output load, running, base, exponent, modulus,
    input  result, over, err
  );

  modport slave (
    input  load, running, base, exponent, modulus,
    output result, over, err
  );
endinterface

// File: rtl/mod_exp_engine.sv
// Fixed-schedule square-and-multiply modular exponentiation, result = base^exponent mod modulus.
// Each modular multiply is bit-serial interleaved, one multiplier bit per cycle, so the
// latency depends only on WIDTH and the number of stalled cycles, never on the data.
module mod_exp_engine #(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       reset,
  mod_exp_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, SQR, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic [CW-1:0]    stepCnt_q, stepCnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             over_q, over_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] mulX;
  logic             yBit;
  logic [WIDTH:0]   mExt, pIn, pDbl, pSub, pAdd, pNext;

  // One interleaved shift/add/subtract step of modmul(X, B); X is R in MUL and B in SQR.
  always_comb begin
    mulX  = (state_q == SQR) ? b_q : r_q;
    yBit  = b_q[stepCnt_q];
    mExt  = {1'b0, m_q};
    pIn   = (stepCnt_q == LAST) ? '0 : p_q;
    pDbl  = pIn << 1;
    pSub  = (pDbl >= mExt) ? (pDbl - mExt) : pDbl;
    pAdd  = yBit ? (pSub + {1'b0, mulX}) : pSub;
    pNext = (pAdd >= mExt) ? (pAdd - mExt) : pAdd;
  end

  // Next-state logic: load restarts from any state, running gates every step except FIN.
  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    r_d       = r_q;
    e_d       = e_q;
    m_d       = m_q;
    p_d       = p_q;
    bitCnt_d  = bitCnt_q;
    stepCnt_d = stepCnt_q;
    result_d  = result_q;
    over_d    = 1'b0;
    err_d     = err_q;
    if (bus.load) begin
      m_d       = bus.modulus;
      e_d       = bus.exponent;
      b_d       = bus.base;
      r_d       = (bus.modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
      bitCnt_d  = LAST;
      stepCnt_d = LAST;
      result_d  = '0;
      err_d     = (bus.modulus == '0) || (bus.base >= bus.modulus);
      state_d   = MUL;
    end else begin
      case (state_q)
        MUL: begin
          if (bus.running) begin
            p_d = pNext;
            if (stepCnt_q == '0) begin
              if (e_q[0]) r_d = pNext[WIDTH-1:0];
              stepCnt_d = LAST;
              state_d   = SQR;
            end else begin
              stepCnt_d = stepCnt_q - 1'b1;
            end
          end
        end
        SQR: begin
          if (bus.running) begin
            p_d = pNext;
            if (stepCnt_q == '0) begin
              b_d       = pNext[WIDTH-1:0];
              e_d       = e_q >> 1;
              stepCnt_d = LAST;
              if (bitCnt_q == '0) begin
                state_d = FIN;
              end else begin
                bitCnt_d = bitCnt_q - 1'b1;
                state_d  = MUL;
              end
            end else begin
              stepCnt_d = stepCnt_q - 1'b1;
            end
          end
        end
        FIN: begin
          result_d = err_q ? '0 : r_q;
          over_d   = 1'b1;
          state_d  = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset that aborts any run in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      b_q       <= '0;
      r_q       <= '0;
      e_q       <= '0;
      m_q       <= '0;
      p_q       <= '0;
      bitCnt_q  <= '0;
      stepCnt_q <= '0;
      result_q  <= '0;
      over_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      r_q       <= r_d;
      e_q       <= e_d;
      m_q       <= m_d;
      p_q       <= p_d;
      bitCnt_q  <= bitCnt_d;
      stepCnt_q <= stepCnt_d;
      result_q  <= result_d;
      over_q    <= over_d;
      err_q     <= err_d;
    end
  end

  assign bus.result = result_q;
  assign bus.over   = over_q;
  assign bus.err    = err_q;

endmodule
